flush_recovery_controller: RTL and testbench

- Sequences pipeline recovery after a branch mispredict.
- Broadcasts the squash to the instruction queue and holds off new inserts from decode/rename.
- Walks the active list from its tail back to the mispredicted entry, one entry per cycle, restoring rename-map mappings and releasing freed physical registers.
- Rewinds the active-list tail, then pulses done so insertion resumes.

---
 rtl/mips_core_pkg.sv | 22 ++
 rtl/al_age_compare.sv | 11 +
 rtl/flush_recovery_controller.sv | 135 +++++++++++++
 tb/tb_flush_recovery_controller.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared core types: active-list and register index widths plus the flush FSM encoding.
package mips_core_pkg;
  localparam int AL_DEPTH = 32;
  localparam int AL_IDX_W = $clog2(AL_DEPTH);
  localparam int PREG_W   = 6;
  localparam int AREG_W   = 5;
  localparam int ID_W     = 32;

  typedef logic [AL_IDX_W-1:0] AlIndex;
  typedef logic [PREG_W-1:0]   PhysReg;
  typedef logic [AREG_W-1:0]   ArchReg;
  typedef logic [ID_W-1:0]     InstId;

  typedef enum logic [1:0] {IDLE, SQUASH, WALK, DONE} FlushState;

  localparam AlIndex AL_ONE = AlIndex'(1);

  // Distance from the oldest entry; the active list wraps, so modulo arithmetic is the age.
  function automatic AlIndex al_age(input AlIndex x, input AlIndex head);
    return AlIndex'(x - head);
  endfunction
endpackage

// File: rtl/al_age_compare.sv
// Combinational age compare of two active-list slots relative to the list head.
module al_age_compare
  import mips_core_pkg::*;
(
  input  logic [AL_IDX_W-1:0] a,
  input  logic [AL_IDX_W-1:0] b,
  input  logic [AL_IDX_W-1:0] head,
  output logic                a_older
);
  assign a_older = al_age(a, head) < al_age(b, head);
endmodule

// File: rtl/flush_recovery_controller.sv
// Branch-mispredict recovery: squash the IQ, walk the active list youngest-first restoring
// rename mappings and freeing physical registers, then rewind the tail and signal done.
module flush_recovery_controller
  import mips_core_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_req,
  input  logic [AL_IDX_W-1:0] flush_al_index,
  input  logic [ID_W-1:0]     flush_instruction_ID,
  input  logic [AL_IDX_W-1:0] al_head,
  input  logic [AL_IDX_W-1:0] al_tail,
  output logic [AL_IDX_W-1:0] al_rd_index,
  input  logic                al_rd_uses_rw,
  input  logic [AREG_W-1:0]   al_rd_arch_reg,
  input  logic [PREG_W-1:0]   al_rd_new_preg,
  input  logic [PREG_W-1:0]   al_rd_old_preg,
  output logic                iq_flush,
  output logic [ID_W-1:0]     iq_flushed_instruction_ID,
  output logic                insert_block,
  output logic                map_restore_valid,
  output logic [AREG_W-1:0]   map_restore_arch,
  output logic [PREG_W-1:0]   map_restore_preg,
  output logic                free_release_valid,
  output logic [PREG_W-1:0]   free_release_preg,
  output logic                al_tail_set_valid,
  output logic [AL_IDX_W-1:0] al_tail_set_value,
  output logic                flush_done,
  output logic                busy
);
  FlushState state, next_state;
  AlIndex    walk_ptr, stop_idx, walk_dec, eff_stop;
  InstId     cap_id;
  logic      new_older, new_before_walk, retarget, passed;

  logic      iq_flush_d, restore_d, tail_set_d, blk_d;
  ArchReg    arch_d;
  PhysReg    old_d, new_d;
  AlIndex    tail_val_d;

  al_age_compare u_new_vs_stop (.a(flush_al_index), .b(stop_idx), .head(al_head), .a_older(new_older));
  al_age_compare u_new_vs_walk (.a(flush_al_index), .b(walk_ptr), .head(al_head), .a_older(new_before_walk));

  // Only a strictly older mispredict mid-recovery moves the stop point; the walk itself keeps going.
  assign retarget    = flush_req && (state == SQUASH || state == WALK) && new_older;
  assign passed      = retarget && !new_before_walk;
  assign eff_stop    = retarget ? flush_al_index : stop_idx;
  assign walk_dec    = walk_ptr - AL_ONE;
  assign al_rd_index = walk_ptr;
  assign iq_flushed_instruction_ID = cap_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (flush_req) next_state = SQUASH;
      SQUASH:  next_state = (passed || walk_ptr == eff_stop) ? DONE : WALK;
      WALK:    next_state = (passed || walk_dec == eff_stop) ? DONE : WALK;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      walk_ptr <= '0;
      stop_idx <= '0;
      cap_id   <= '0;
    end else if (state == IDLE && flush_req) begin
      walk_ptr <= al_tail - AL_ONE;
      stop_idx <= flush_al_index;
      cap_id   <= flush_instruction_ID;
    end else begin
      if (retarget) begin
        stop_idx <= flush_al_index;
        cap_id   <= flush_instruction_ID;
      end
      if (state == WALK) walk_ptr <= walk_dec;
    end
  end

  // Next-cycle output values; everything except the read index leaves through a flop.
  always_comb begin
    iq_flush_d = (state == IDLE && flush_req) || retarget;
    restore_d  = 1'b0;
    arch_d     = '0;
    old_d      = '0;
    new_d      = '0;
    tail_set_d = 1'b0;
    tail_val_d = '0;
    blk_d      = (next_state != IDLE);
    if (state == WALK && al_rd_uses_rw && !passed) begin
      restore_d = 1'b1;
      arch_d    = al_rd_arch_reg;
      old_d     = al_rd_old_preg;
      new_d     = al_rd_new_preg;
    end
    if (next_state == DONE) begin
      tail_set_d = 1'b1;
      tail_val_d = eff_stop + AL_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iq_flush           <= 1'b0;
      insert_block       <= 1'b0;
      busy               <= 1'b0;
      map_restore_valid  <= 1'b0;
      map_restore_arch   <= '0;
      map_restore_preg   <= '0;
      free_release_valid <= 1'b0;
      free_release_preg  <= '0;
      al_tail_set_valid  <= 1'b0;
      al_tail_set_value  <= '0;
      flush_done         <= 1'b0;
    end else begin
      iq_flush           <= iq_flush_d;
      insert_block       <= blk_d;
      busy               <= blk_d;
      map_restore_valid  <= restore_d;
      map_restore_arch   <= arch_d;
      map_restore_preg   <= old_d;
      free_release_valid <= restore_d;
      free_release_preg  <= new_d;
      al_tail_set_valid  <= tail_set_d;
      al_tail_set_value  <= tail_val_d;
      flush_done         <= tail_set_d;
    end
  end
endmodule

// File: tb/tb_flush_recovery_controller.sv
// Table-driven bench for flush_recovery_controller with a restore/release event scoreboard.
module tb_flush_recovery_controller;
  import mips_core_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush_req = 1'b0;
  logic [4:0]        flush_al_index = '0;
  logic [31:0]       flush_instruction_ID = '0;
  logic [4:0]        al_head = '0, al_tail = '0, al_rd_index;
  logic              al_rd_uses_rw;
  logic [4:0]        al_rd_arch_reg;
  logic [5:0]        al_rd_new_preg, al_rd_old_preg;
  logic              iq_flush, insert_block, map_restore_valid, free_release_valid;
  logic              al_tail_set_valid, flush_done, busy;
  logic [31:0]       iq_flushed_instruction_ID;
  logic [4:0]        map_restore_arch, al_tail_set_value;
  logic [5:0]        map_restore_preg, free_release_preg;

  int checks = 0;
  int errors = 0;
  int skip_slot = -1;

  flush_recovery_controller dut (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .flush_al_index(flush_al_index),
    .flush_instruction_ID(flush_instruction_ID), .al_head(al_head), .al_tail(al_tail),
    .al_rd_index(al_rd_index), .al_rd_uses_rw(al_rd_uses_rw), .al_rd_arch_reg(al_rd_arch_reg),
    .al_rd_new_preg(al_rd_new_preg), .al_rd_old_preg(al_rd_old_preg), .iq_flush(iq_flush),
    .iq_flushed_instruction_ID(iq_flushed_instruction_ID), .insert_block(insert_block),
    .map_restore_valid(map_restore_valid), .map_restore_arch(map_restore_arch),
    .map_restore_preg(map_restore_preg), .free_release_valid(free_release_valid),
    .free_release_preg(free_release_preg), .al_tail_set_valid(al_tail_set_valid),
    .al_tail_set_value(al_tail_set_value), .flush_done(flush_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Active-list contents as a function of the slot number.
  always_comb begin
    al_rd_uses_rw  = (int'(al_rd_index) != skip_slot);
    al_rd_arch_reg = al_rd_index ^ 5'h15;
    al_rd_new_preg = 6'(al_rd_index) + 6'd37;
    al_rd_old_preg = 6'(al_rd_index) + 6'd7;
  end

  typedef struct {
    int cyc;
    int arch;
    int oldp;
    int newp;
  } ev_t;
  ev_t sbq[$];

  typedef struct {
    int head, tail, idx, id, lat, etail, skip, rcyc, ridx, rid, r_eff;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_events(input int tail, input int stop, input int skip);
    int n;
    int slot;
    n = (tail - stop - 1) & 31;
    for (int j = 0; j < n; j++) begin
      slot = (tail - 1 - j) & 31;
      if (slot != skip) sbq.push_back('{3 + j, slot ^ 21, (slot + 7) & 63, (slot + 37) & 63});
    end
  endtask

  task automatic run(input vec_t v, input int n);
    ev_t e;
    logic rv, exp_iq;
    skip_slot = v.skip;
    al_head = 5'(v.head);
    al_tail = 5'(v.tail);
    sbq.delete();
    push_events(v.tail, (v.r_eff != 0) ? v.ridx : v.idx, v.skip);
    @(posedge clk); #1;
    flush_req = 1'b1;
    flush_al_index = 5'(v.idx);
    flush_instruction_ID = v.id;
    for (int k = 1; k <= v.lat + 1; k++) begin
      @(posedge clk); #1;
      flush_req = (k == v.rcyc);
      flush_al_index = 5'(v.ridx);
      flush_instruction_ID = v.rid;
      @(negedge clk);
      exp_iq = (k == 1) || (v.r_eff != 0 && k == v.rcyc + 1);
      chk($sformatf("v%0d c%0d iq_flush", n, k), iq_flush, exp_iq);
      if (exp_iq)
        chk($sformatf("v%0d c%0d iq_id", n, k), iq_flushed_instruction_ID, (k == 1) ? v.id : v.rid);
      chk($sformatf("v%0d c%0d insert_block", n, k), insert_block, k <= v.lat);
      chk($sformatf("v%0d c%0d busy", n, k), busy, k <= v.lat);
      chk($sformatf("v%0d c%0d flush_done", n, k), flush_done, k == v.lat);
      chk($sformatf("v%0d c%0d tail_set_valid", n, k), al_tail_set_valid, k == v.lat);
      if (k == v.lat) chk($sformatf("v%0d tail_set_value", n), al_tail_set_value, v.etail);
      rv = (sbq.size() > 0) && (sbq[0].cyc == k);
      chk($sformatf("v%0d c%0d restore_valid", n, k), map_restore_valid, rv);
      chk($sformatf("v%0d c%0d release_valid", n, k), free_release_valid, rv);
      if (rv) begin
        e = sbq.pop_front();
        chk($sformatf("v%0d c%0d restore_arch", n, k), map_restore_arch, e.arch);
        chk($sformatf("v%0d c%0d restore_preg", n, k), map_restore_preg, e.oldp);
        chk($sformatf("v%0d c%0d release_preg", n, k), free_release_preg, e.newp);
      end
    end
    chk($sformatf("v%0d scoreboard_empty", n), sbq.size(), 0);
    sbq.delete();
    repeat (2) @(posedge clk);
  endtask

  initial begin
    // head, tail, idx, id, lat, etail, skip, rcyc, ridx, rid, r_eff
    vecs[0] = '{0, 6, 2, 'h40, 5, 3, -1, 0, 0, 0, 0};          // basic walk
    vecs[1] = '{0, 3, 2, 'h55, 2, 3, -1, 0, 0, 0, 0};          // no younger entries
    vecs[2] = '{28, 2, 30, 'h77, 5, 31, -1, 0, 0, 0, 0};       // wrap-around 1,0,31
    vecs[3] = '{0, 8, 2, 'h99, 7, 3, 4, 0, 0, 0, 0};           // slot 4 writes nothing
    vecs[4] = '{10, 10, 10, 'hA0, 33, 11, -1, 0, 0, 0, 0};     // full list, 31 entries
    vecs[5] = '{0, 10, 5, 'h20, 8, 4, -1, 4, 3, 'h21, 1};      // older flush at walk_ptr=7
    vecs[6] = '{0, 10, 5, 'h30, 6, 6, -1, 4, 8, 'h31, 0};      // younger flush ignored

    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst insert_block", insert_block, 0);
    chk("rst flags", {iq_flush, map_restore_valid, free_release_valid, al_tail_set_valid, flush_done}, 0);
    chk("rst al_rd_index", al_rd_index, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) run(vecs[i], i);

    // Reset in the middle of a walk aborts at once.
    skip_slot = -1;
    al_head = 5'd0;
    al_tail = 5'd10;
    @(posedge clk); #1;
    flush_req = 1'b1;
    flush_al_index = 5'd2;
    flush_instruction_ID = 32'h33;
    @(posedge clk); #1;
    flush_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst busy", busy, 1);
    chk("pre_rst restore_valid", map_restore_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst flags", {iq_flush, insert_block, busy, map_restore_valid, free_release_valid,
                          al_tail_set_valid, flush_done}, 0);
    chk("mid_rst values", {iq_flushed_instruction_ID, map_restore_arch, map_restore_preg,
                           free_release_preg, al_tail_set_value, al_rd_index}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst busy", busy, 0);
    chk("post_rst insert_block", insert_block, 0);
    run(vecs[0], 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
